// File: rtl/aes128_pkg.sv
// aes128_pkg: shared types for the aes128 AFU DSM status writer and its CCI-P channel-1 view
package aes128_pkg;
  localparam int DSM_SEQ_WIDTH = 16;
  typedef logic [41:0] t_hc_address;
  typedef logic [DSM_SEQ_WIDTH-1:0] t_dsm_seq;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} t_dsm_state;
  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;
  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;
  typedef enum logic [1:0] {eVC_VA, eVC_VL0, eVC_VH0, eVC_VH1} t_ccip_vc;
  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;
  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_hc_address  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;
  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         hit_miss;
    logic         format;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;
  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic [511:0]       data;
    logic               valid;
  } t_if_ccip_c1_Tx;
  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
  // word0 occupies the low 64 bits so the line is little-endian by word
  typedef struct packed {
    logic [63:0] w7, w6, w5, w4, w3, w2, w1, w0;
  } t_dsm_line;
  function automatic t_dsm_line dsm_line(t_dsm_seq seq, logic [31:0] status, logic [63:0] cycles);
    t_dsm_line l;
    l = '0;
    l.w0 = {32'h0, 16'h0, seq};
    l.w1 = {32'h0, status};
    l.w2 = cycles;
    return l;
  endfunction
endpackage

// File: rtl/aes128_dsm_writer.sv
// aes128_dsm_writer: writes one completion-status line per report to host DSM over CCI-P c1 and waits for its response
module aes128_dsm_writer
  import aes128_pkg::*;
#(
  parameter int unsigned DSM_LINE_OFFSET = 0,
  parameter int unsigned RSP_TIMEOUT     = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  t_hc_address    hc_dsm_base,
  input  logic           rpt_valid,
  output logic           rpt_ready,
  input  logic [31:0]    rpt_status,
  input  logic [63:0]    rpt_cycles,
  output t_if_ccip_c1_Tx c1Tx,
  input  logic           c1TxAlmFull,
  input  t_if_ccip_c1_Rx c1Rx,
  output logic           busy,
  output logic           err_timeout,
  output logic           err_nobase
);
  localparam int CW = $clog2(RSP_TIMEOUT + 1);
  t_dsm_state     state_q, state_d;
  t_dsm_seq       seq_q, seq_d;
  logic [31:0]    status_q, status_d;
  logic [63:0]    cycles_q, cycles_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  t_if_ccip_c1_Tx c1tx_q, c1tx_d;
  logic           err_timeout_q, err_timeout_d;
  logic           err_nobase_q, err_nobase_d;
  logic           accept, rsp_match, unused_rsp_bits;
  assign rpt_ready = (state_q == IDLE) && !reset;
  assign accept = rpt_valid && rpt_ready;
  assign rsp_match = c1Rx.rspValid && c1Rx.hdr.resp_type == eRSP_WRLINE && c1Rx.hdr.mdata == seq_q;
  assign unused_rsp_bits = ^{c1Rx.hdr.vc_used, c1Rx.hdr.hit_miss, c1Rx.hdr.format, c1Rx.hdr.cl_num};
  assign c1Tx = c1tx_q;
  assign busy = state_q != IDLE;
  assign err_timeout = err_timeout_q;
  assign err_nobase = err_nobase_q;
  // next-state: accept report, issue one write line when not back-pressured, then wait for its tagged response
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    status_d = status_q;
    cycles_d = cycles_q;
    cnt_d = cnt_q;
    c1tx_d = c1tx_q;
    c1tx_d.valid = 1'b0;
    err_timeout_d = err_timeout_q;
    err_nobase_d = err_nobase_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (hc_dsm_base == '0) err_nobase_d = 1'b1;
        else begin
          status_d = rpt_status;
          cycles_d = rpt_cycles;
          seq_d = seq_q + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: if (!c1TxAlmFull) begin
        c1tx_d.valid = 1'b1;
        c1tx_d.hdr = '0;
        c1tx_d.hdr.req_type = eREQ_WRLINE_I;
        c1tx_d.hdr.vc_sel = eVC_VA;
        c1tx_d.hdr.sop = 1'b1;
        c1tx_d.hdr.cl_len = eCL_LEN_1;
        c1tx_d.hdr.address = hc_dsm_base + t_hc_address'(DSM_LINE_OFFSET);
        c1tx_d.hdr.mdata = seq_q;
        c1tx_d.data = dsm_line(seq_q, status_q, cycles_q);
        cnt_d = '0;
        state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (rsp_match) state_d = IDLE;
        else if (cnt_q == CW'(RSP_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q <= '0;
      status_q <= '0;
      cycles_q <= '0;
      cnt_q <= '0;
      c1tx_q <= '0;
      err_timeout_q <= 1'b0;
      err_nobase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      status_q <= status_d;
      cycles_q <= cycles_d;
      cnt_q <= cnt_d;
      c1tx_q <= c1tx_d;
      err_timeout_q <= err_timeout_d;
      err_nobase_q <= err_nobase_d;
    end
  end
endmodule

// File: tb/tb_aes128_dsm_writer.sv
// tb_aes128_dsm_writer: directed self-checking bench for the DSM status writer
module tb_aes128_dsm_writer;
  import aes128_pkg::*;
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  t_hc_address    hc_dsm_base;
  logic           rpt_valid, rpt_ready;
  logic [31:0]    rpt_status;
  logic [63:0]    rpt_cycles;
  t_if_ccip_c1_Tx c1Tx;
  logic           c1TxAlmFull;
  t_if_ccip_c1_Rx c1Rx;
  logic           busy, err_timeout, err_nobase;
  int n_chk = 0, n_pass = 0, n_req = 0, req_snap;
  always #5 clk = ~clk;
  aes128_dsm_writer #(.DSM_LINE_OFFSET(0), .RSP_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .hc_dsm_base(hc_dsm_base), .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready), .rpt_status(rpt_status), .rpt_cycles(rpt_cycles),
    .c1Tx(c1Tx), .c1TxAlmFull(c1TxAlmFull), .c1Rx(c1Rx), .busy(busy),
    .err_timeout(err_timeout), .err_nobase(err_nobase)
  );
  // count issued write requests
  always @(posedge clk) if (c1Tx.valid) n_req <= n_req + 1;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic report(t_hc_address base, logic [31:0] st, logic [63:0] cy);
    hc_dsm_base = base;
    rpt_status = st;
    rpt_cycles = cy;
    rpt_valid = 1'b1;
    step();
    rpt_valid = 1'b0;
  endtask
  task automatic respond(logic [15:0] md, t_ccip_c1_rsp rt);
    c1Rx.hdr.mdata = md;
    c1Rx.hdr.resp_type = rt;
    c1Rx.rspValid = 1'b1;
    step();
    c1Rx.rspValid = 1'b0;
  endtask
  task automatic check_req(string tag, t_hc_address addr, logic [15:0] sq, logic [31:0] st, logic [63:0] cy);
    check({tag, ".valid"}, 64'(c1Tx.valid), 64'(1));
    check({tag, ".req_type"}, 64'(c1Tx.hdr.req_type), 64'(eREQ_WRLINE_I));
    check({tag, ".vc_sel"}, 64'(c1Tx.hdr.vc_sel), 64'(eVC_VA));
    check({tag, ".sop"}, 64'(c1Tx.hdr.sop), 64'(1));
    check({tag, ".cl_len"}, 64'(c1Tx.hdr.cl_len), 64'(eCL_LEN_1));
    check({tag, ".addr"}, 64'(c1Tx.hdr.address), 64'(addr));
    check({tag, ".mdata"}, 64'(c1Tx.hdr.mdata), 64'(sq));
    check({tag, ".word0"}, c1Tx.data[63:0], {48'h0, sq});
    check({tag, ".word1"}, c1Tx.data[127:64], {32'h0, st});
    check({tag, ".word2"}, c1Tx.data[191:128], cy);
    check({tag, ".word3to7_zero"}, 64'(c1Tx.data[511:192] == '0), 64'(1));
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, ".ready"}, 64'(rpt_ready), 64'(0));
    check({tag, ".valid"}, 64'(c1Tx.valid), 64'(0));
    check({tag, ".hdr_zero"}, 64'(c1Tx.hdr == '0), 64'(1));
    check({tag, ".data_zero"}, 64'(c1Tx.data == '0), 64'(1));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".err_timeout"}, 64'(err_timeout), 64'(0));
    check({tag, ".err_nobase"}, 64'(err_nobase), 64'(0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    hc_dsm_base = '0;
    rpt_valid = 1'b0;
    rpt_status = '0;
    rpt_cycles = '0;
    c1TxAlmFull = 1'b0;
    c1Rx = '0;
    step(2);
    check_reset_outputs("rst");
    reset = 1'b0;
    step();
    check("rst.ready_after", 64'(rpt_ready), 64'(1));
    report(42'h1000, 32'hA5, 64'd77);
    check("t1.no_early_valid", 64'(c1Tx.valid), 64'(0));
    check("t1.busy", 64'(busy), 64'(1));
    step();
    check_req("t1", 42'h1000, 16'd1, 32'hA5, 64'd77);
    step();
    check("t1.one_pulse", 64'(c1Tx.valid), 64'(0));
    check("t1.ready_wait", 64'(rpt_ready), 64'(0));
    respond(16'd1, eRSP_WRLINE);
    check("t1.ready_back", 64'(rpt_ready), 64'(1));
    check("t1.nreq", 64'(n_req), 64'(1));
    c1TxAlmFull = 1'b1;
    report(42'h1000, 32'h1, 64'd2);
    step(19);
    check("t2.held_nreq", 64'(n_req), 64'(1));
    check("t2.held_valid", 64'(c1Tx.valid), 64'(0));
    check("t2.busy", 64'(busy), 64'(1));
    c1TxAlmFull = 1'b0;
    step();
    check_req("t2", 42'h1000, 16'd2, 32'h1, 64'd2);
    step();
    check("t2.nreq", 64'(n_req), 64'(2));
    respond(16'd2, eRSP_WRLINE);
    check("t2.err_timeout", 64'(err_timeout), 64'(0));
    check("t2.ready", 64'(rpt_ready), 64'(1));
    report(42'h1000, 32'h3, 64'd3);
    step();
    check("t3.mdata", 64'(c1Tx.hdr.mdata), 64'd3);
    step();
    respond(16'd5, eRSP_WRLINE);
    check("t3.bad_mdata_busy", 64'(busy), 64'(1));
    respond(16'd3, eRSP_WRFENCE);
    check("t3.bad_type_busy", 64'(busy), 64'(1));
    respond(16'd3, eRSP_WRLINE);
    check("t3.ready", 64'(rpt_ready), 64'(1));
    report(42'h1000, 32'h4, 64'd4);
    step();
    check("t4.mdata", 64'(c1Tx.hdr.mdata), 64'd4);
    step(15);
    check("t4.busy_last", 64'(busy), 64'(1));
    respond(16'd4, eRSP_WRLINE);
    check("t4.idle", 64'(busy), 64'(0));
    check("t4.rsp_beats_timeout", 64'(err_timeout), 64'(0));
    report(42'h1000, 32'h5, 64'd5);
    step();
    check("t5.mdata", 64'(c1Tx.hdr.mdata), 64'd5);
    step(15);
    check("t5.busy_before", 64'(busy), 64'(1));
    check("t5.err_before", 64'(err_timeout), 64'(0));
    step();
    check("t5.busy_after", 64'(busy), 64'(0));
    check("t5.err_timeout", 64'(err_timeout), 64'(1));
    check("t5.ready", 64'(rpt_ready), 64'(1));
    report(42'h1000, 32'h6, 64'd6);
    step();
    check("t5.next_mdata", 64'(c1Tx.hdr.mdata), 64'd6);
    step();
    respond(16'd6, eRSP_WRLINE);
    req_snap = n_req;
    report(42'h0, 32'h7, 64'd7);
    check("t6.err_nobase", 64'(err_nobase), 64'(1));
    check("t6.busy", 64'(busy), 64'(0));
    check("t6.ready", 64'(rpt_ready), 64'(1));
    step(3);
    check("t6.no_req", 64'(n_req), 64'(req_snap));
    report(42'h1000, 32'h8, 64'd8);
    step();
    check("t6.seq_kept", 64'(c1Tx.hdr.mdata), 64'd7);
    step();
    respond(16'd7, eRSP_WRLINE);
    force dut.seq_q = 16'hFFFF;
    step();
    release dut.seq_q;
    report(42'h1000, 32'hBEEF, 64'h1234);
    step();
    check_req("t7", 42'h1000, 16'd0, 32'hBEEF, 64'h1234);
    step();
    respond(16'd0, eRSP_WRLINE);
    check("t7.ready", 64'(rpt_ready), 64'(1));
    report(42'h1000, 32'h9, 64'd9);
    step();
    check("t8.mdata1", 64'(c1Tx.hdr.mdata), 64'd1);
    respond(16'd1, eRSP_WRLINE);
    report(42'h1000, 32'hA, 64'd10);
    step();
    check("t8.mdata2", 64'(c1Tx.hdr.mdata), 64'd2);
    step(2);
    reset = 1'b1;
    step();
    check_reset_outputs("t8.rst");
    reset = 1'b0;
    step();
    report(42'h1000, 32'hB, 64'd11);
    step();
    check("t8.seq_cleared", 64'(c1Tx.hdr.mdata), 64'd1);
    step();
    respond(16'd2, eRSP_WRLINE);
    check("t8.stale_ignored", 64'(busy), 64'(1));
    respond(16'd1, eRSP_WRLINE);
    check("t8.ready", 64'(rpt_ready), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
